// File: rtl/mem_arbiter.sv
// Shares the single data-memory bus between the Icache and Dcache, routing tickets
// and completion tags back to the issuing cache. A starvation counter bounds Icache lockout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_BITS     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Icache2mem_command,
    input  logic [63:0] Icache2mem_addr,
    input  logic [1:0]  Dcache2mem_command,
    input  logic [63:0] Dcache2mem_addr,
    input  logic [63:0] Dcache2mem_data,
    output logic [3:0]  mem2Icache_response,
    output logic [3:0]  mem2Icache_tag,
    output logic [63:0] mem2Icache_data,
    output logic [3:0]  mem2Dcache_response,
    output logic [3:0]  mem2Dcache_tag,
    output logic [63:0] mem2Dcache_data,
    output logic [1:0]  arb2mem_command,
    output logic [63:0] arb2mem_addr,
    output logic [63:0] arb2mem_data,
    input  logic [3:0]  mem2arb_response,
    input  logic [3:0]  mem2arb_tag,
    input  logic [63:0] mem2arb_data,
    output logic        grant_dcache,
    output logic        orphan_err
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(STARVE_LIMIT);

    logic [CNT_BITS-1:0] starve_cnt;
    // Bit 0 of each table vector is never written: ticket 0 means "none".
    logic [15:0] tbl_valid;
    logic [15:0] tbl_owner;

    logic i_req, d_req, grant_i, grant_d;
    logic tag_present, tag_hit, tbl_set;

    always_comb begin
        i_req   = (Icache2mem_command != BUS_NONE);
        d_req   = (Dcache2mem_command != BUS_NONE);
        grant_d = d_req && !(i_req && (starve_cnt == LIMIT));
        grant_i = i_req && !grant_d;

        arb2mem_command = BUS_NONE;
        arb2mem_addr    = '0;
        arb2mem_data    = '0;
        if (grant_d) begin
            arb2mem_command = Dcache2mem_command;
            arb2mem_addr    = Dcache2mem_addr;
            arb2mem_data    = Dcache2mem_data;
        end else if (grant_i) begin
            arb2mem_command = Icache2mem_command;
            arb2mem_addr    = Icache2mem_addr;
        end

        mem2Icache_response = grant_i ? mem2arb_response : '0;
        mem2Dcache_response = grant_d ? mem2arb_response : '0;
        grant_dcache        = grant_d;

        tag_present    = (mem2arb_tag != '0);
        tag_hit        = tag_present && tbl_valid[mem2arb_tag];
        mem2Icache_tag = (tag_hit && !tbl_owner[mem2arb_tag]) ? mem2arb_tag : '0;
        mem2Dcache_tag = (tag_hit &&  tbl_owner[mem2arb_tag]) ? mem2arb_tag : '0;

        mem2Icache_data = mem2arb_data;
        mem2Dcache_data = mem2arb_data;

        tbl_set = (arb2mem_command == BUS_LOAD) && (mem2arb_response != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            tbl_valid  <= '0;
            tbl_owner  <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (i_req && !grant_i)
                starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;

            if (tag_hit)
                tbl_valid[mem2arb_tag] <= 1'b0;
            else if (tag_present)
                orphan_err <= 1'b1;

            // Later assignment wins when a completing ticket is reissued this cycle.
            if (tbl_set) begin
                tbl_valid[mem2arb_response] <= 1'b1;
                tbl_owner[mem2arb_response] <= grant_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter, checked against a ticket-table
// reference model held in plain arrays.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  ic = '0, dc = '0;
    logic [63:0] ia = '0, da = '0, dd = '0, md = '0;
    logic [3:0]  mr = '0, mt = '0;

    logic [3:0]  i_resp, i_tag, d_resp, d_tag;
    logic [63:0] i_data, d_data, a_addr, a_data;
    logic [1:0]  a_cmd;
    logic        g_d, orph;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_BITS(3)) dut (
        .clock(clock), .reset(reset),
        .Icache2mem_command(ic), .Icache2mem_addr(ia),
        .Dcache2mem_command(dc), .Dcache2mem_addr(da), .Dcache2mem_data(dd),
        .mem2Icache_response(i_resp), .mem2Icache_tag(i_tag), .mem2Icache_data(i_data),
        .mem2Dcache_response(d_resp), .mem2Dcache_tag(d_tag), .mem2Dcache_data(d_data),
        .arb2mem_command(a_cmd), .arb2mem_addr(a_addr), .arb2mem_data(a_data),
        .mem2arb_response(mr), .mem2arb_tag(mt), .mem2arb_data(md),
        .grant_dcache(g_d), .orphan_err(orph)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_starve = 0;
    bit m_valid[16];
    bit m_owner[16];
    bit m_orphan = 0;
    bit mem_busy[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_starve = 0;
        m_orphan = 0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_owner[i] = 0; mem_busy[i] = 0;
        end
    endtask

    function automatic bit model_dwins();
        bit ir = (ic != NONE);
        bit dr = (dc != NONE);
        return dr && (!ir || m_starve != STARVE_LIMIT);
    endfunction

    function automatic logic [1:0] model_wcmd();
        if (model_dwins()) return dc;
        return ic;
    endfunction

    // Apply current inputs, check all outputs against the model, advance one clock.
    task automatic cyc();
        bit gd, gi, hit;
        logic [1:0] wc;
        #1;
        gd  = model_dwins();
        gi  = (ic != NONE) && !gd;
        wc  = gd ? dc : (gi ? ic : NONE);
        hit = (mt != 0) && m_valid[mt];
        chk("grant_dcache", 64'(g_d), 64'(gd));
        chk("arb_cmd",  64'(a_cmd), 64'(wc));
        chk("arb_addr", a_addr, gd ? da : (gi ? ia : 64'd0));
        chk("arb_data", a_data, gd ? dd : 64'd0);
        chk("i_resp", 64'(i_resp), gi ? 64'(mr) : 64'd0);
        chk("d_resp", 64'(d_resp), gd ? 64'(mr) : 64'd0);
        chk("i_tag",  64'(i_tag), (hit && !m_owner[mt]) ? 64'(mt) : 64'd0);
        chk("d_tag",  64'(d_tag), (hit &&  m_owner[mt]) ? 64'(mt) : 64'd0);
        chk("i_data", i_data, md);
        chk("d_data", d_data, md);
        chk("orphan", 64'(orph), 64'(m_orphan));
        @(posedge clock);
        if (reset) begin
            if (hit) m_valid[mt] = 0;
            else if (mt != 0) m_orphan = 1;
            if (mt != 0) mem_busy[mt] = 0;
            if (wc == LOAD && mr != 0) begin
                m_valid[mr] = 1; m_owner[mr] = gd; mem_busy[mr] = 1;
            end
            if ((ic != NONE) && !gi) m_starve = (m_starve >= STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
            else m_starve = 0;
        end
        #1;
    endtask

    task automatic idle();
        ic = NONE; dc = NONE; ia = '0; da = '0; dd = '0; mr = '0; mt = '0; md = '0;
    endtask

    initial begin
        model_clear();
        idle();
        @(posedge clock); #1;
        // 1: reset held for two cycles, then idle
        reset = 1'b0; model_clear();
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("idle_orphan", 64'(orph), 64'd0);

        // 2: Icache load alone, ticket 3, then completion
        ic = LOAD; ia = 64'h100; mr = 4'd3;
        cyc();
        idle(); cyc();
        mt = 4'd3; md = {8{8'haa}};
        #1; chk("t2_itag", 64'(i_tag), 64'd3); chk("t2_dtag", 64'(d_tag), 64'd0);
        cyc();
        idle(); cyc();

        // 3: contention, both load every cycle, memory always accepts
        for (int k = 0; k < 10; k++) begin
            ic = LOAD; ia = 64'h2000 + 64'(k); dc = LOAD; da = 64'h3000 + 64'(k);
            mr = 4'(k + 4);
            #1; chk("t3_pattern", 64'(g_d), (k % 5 == 4) ? 64'd0 : 64'd1);
            cyc();
        end
        idle();
        reset = 1'b0; model_clear(); cyc(); reset = 1'b1; cyc();

        // 5: Dcache ticket 7 completes while Icache is granted ticket 7
        dc = LOAD; da = 64'h500; mr = 4'd7; cyc();
        idle(); ic = LOAD; ia = 64'h600; mr = 4'd7; mt = 4'd7; md = 64'h77;
        #1; chk("t5_dtag", 64'(d_tag), 64'd7);
        cyc();
        idle(); mt = 4'd7; md = 64'h78;
        #1; chk("t5_itag", 64'(i_tag), 64'd7); chk("t5_dtag2", 64'(d_tag), 64'd0);
        cyc();
        idle(); cyc();

        // randomized traffic against the model with a ticket-issuing memory
        for (int n = 0; n < 300; n++) begin
            int r;
            int s;
            r = $urandom_range(0, 5); ic = (r >= 3) ? LOAD : 2'(r);
            r = $urandom_range(0, 5); dc = (r >= 3) ? LOAD : 2'(r);
            ia = {$urandom, $urandom}; da = {$urandom, $urandom}; dd = {$urandom, $urandom};
            md = {$urandom, $urandom};
            mr = '0; mt = '0;
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(1, 15);
                for (int j = 0; j < 15; j++)
                    if (mt == 0 && mem_busy[((s + j - 1) % 15) + 1]) mt = 4'(((s + j - 1) % 15) + 1);
            end
            if (model_wcmd() != NONE && $urandom_range(0, 4) != 0) begin
                s = $urandom_range(1, 15);
                for (int j = 0; j < 15; j++)
                    if (mr == 0 && !mem_busy[((s + j - 1) % 15) + 1]) mr = 4'(((s + j - 1) % 15) + 1);
            end
            cyc();
        end
        idle();
        reset = 1'b0; model_clear(); cyc(); reset = 1'b1; cyc();

        // 4: store ticket is not recorded; its tag is an orphan
        dc = STORE; da = 64'h40; dd = {8{8'h12}}; mr = 4'd5;
        #1; chk("t4_adata", a_data, {8{8'h12}});
        cyc();
        idle(); mt = 4'd5;
        #1; chk("t4_dtag", 64'(d_tag), 64'd0);
        cyc();
        idle(); cyc();
        chk("t4_orphan", 64'(orph), 64'd1);

        // 6: reset mid-flight forgets ticket 2
        reset = 1'b0; model_clear(); cyc(); reset = 1'b1; cyc();
        ic = LOAD; ia = 64'h880; mr = 4'd2; cyc();
        idle();
        reset = 1'b0; #2; reset = 1'b1; model_clear();
        mt = 4'd2; md = 64'hdead;
        #1; chk("t6_itag", 64'(i_tag), 64'd0); chk("t6_dtag", 64'(d_tag), 64'd0);
        cyc();
        idle(); cyc();
        chk("t6_orphan", 64'(orph), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
